// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes,
// memory-wait freezes with a timeout watchdog, and saturating stall/flush counters.
module pipeline_hazard_controller #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  idex_memread,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic [REG_ADDR_W-1:0] ifid_rs1,
  input  logic [REG_ADDR_W-1:0] ifid_rs2,
  input  logic                  ifid_uses_rs2,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  input  logic                  clr_cnt,
  output logic                  pc_load,
  output logic                  ifid_load,
  output logic                  idex_load,
  output logic                  exmem_load,
  output logic                  memwb_load,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int unsigned BW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {RUN = 1'b0, ERROR = 1'b1} state_t;

  state_t        state;
  logic [BW-1:0] busy_ctr;
  logic          branch_pending;

  logic br_c;
  logic lu_c;
  logic stall_evt_c;
  logic flush_evt_c;
  logic timeout_c;

  assign br_c = branch_taken | branch_pending;
  assign lu_c = idex_memread && (idex_rd != '0) &&
                ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));

  // Mealy load/flush decode, strict priority: error > freeze > branch > load-use
  always_comb begin
    pc_load    = 1'b0;
    ifid_load  = 1'b0;
    idex_load  = 1'b0;
    exmem_load = 1'b0;
    memwb_load = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (rst && (state == RUN) && !mem_busy) begin
      idex_load  = 1'b1;
      exmem_load = 1'b1;
      memwb_load = 1'b1;
      if (br_c) begin
        pc_load    = 1'b1;
        ifid_load  = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (lu_c) begin
        idex_flush = 1'b1;
      end else begin
        pc_load   = 1'b1;
        ifid_load = 1'b1;
      end
    end
  end

  assign stall_evt_c = (state == RUN) && !pc_load;
  assign flush_evt_c = (state == RUN) && !mem_busy && br_c;
  assign timeout_c   = (TIMEOUT != 0) && mem_busy && (busy_ctr == BW'(TIMEOUT - 1));

  // State, watchdog, pending branch and performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= RUN;
      busy_ctr       <= '0;
      branch_pending <= 1'b0;
      halted         <= 1'b0;
      stall_cnt      <= '0;
      flush_cnt      <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_busy) begin
            if (busy_ctr != BW'(TIMEOUT)) busy_ctr <= busy_ctr + BW'(1);
          end else begin
            busy_ctr <= '0;
          end
          branch_pending <= mem_busy & br_c;
          if (clr_cnt) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
          end else begin
            if (stall_evt_c && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_evt_c && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
          end
          if (timeout_c) begin
            state  <= ERROR;
            halted <= 1'b1;
          end
        end
        default: begin
          state  <= ERROR;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomized and directed bench for pipeline_hazard_controller against a cycle-level model.
module tb_pipeline_hazard_controller;

  localparam int unsigned RW  = 5;
  localparam int unsigned TO  = 4;
  localparam int unsigned CW  = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          idex_memread;
  logic [RW-1:0] idex_rd;
  logic [RW-1:0] ifid_rs1;
  logic [RW-1:0] ifid_rs2;
  logic          ifid_uses_rs2;
  logic          branch_taken;
  logic          mem_busy;
  logic          clr_cnt;
  logic          pc_load, ifid_load, idex_load, exmem_load, memwb_load;
  logic          ifid_flush, idex_flush, halted;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
  logic [6:0]    ctrl_w;
  logic [6:0]    last_ctrl;

  int checks = 0;
  int errors = 0;

  // Model state
  bit m_halted;
  bit m_pending;
  int m_busy_run;
  int m_stall;
  int m_flush;

  pipeline_hazard_controller #(.REG_ADDR_W(RW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .clr_cnt(clr_cnt),
    .pc_load(pc_load), .ifid_load(ifid_load), .idex_load(idex_load),
    .exmem_load(exmem_load), .memwb_load(memwb_load),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign ctrl_w = {pc_load, ifid_load, idex_load, exmem_load, memwb_load, ifid_flush, idex_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {pc,ifid,idex,exmem,memwb,ifid_flush,idex_flush} for the current inputs
  function automatic logic [6:0] exp_ctrl();
    bit br, lu;
    br = branch_taken || m_pending;
    lu = idex_memread && (idex_rd != 0) &&
         ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));
    if (!rst || m_halted || mem_busy) return 7'b0000000;
    if (br) return 7'b1111111;
    if (lu) return 7'b0011101;
    return 7'b1111100;
  endfunction

  task automatic model_edge(input logic [6:0] e);
    if (m_halted) return;
    if (clr_cnt) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (!e[6] && m_stall < CMAX) m_stall++;
      if (!mem_busy && (branch_taken || m_pending) && m_flush < CMAX) m_flush++;
    end
    m_pending  = mem_busy && (m_pending || branch_taken);
    m_busy_run = mem_busy ? m_busy_run + 1 : 0;
    if (m_busy_run >= TO) m_halted = 1;
  endtask

  task automatic step();
    logic [6:0] e;
    @(negedge clk);
    e = exp_ctrl();
    last_ctrl = ctrl_w;
    check("ctrl", 32'(ctrl_w), 32'(e));
    check("halted", 32'(halted), 32'(m_halted));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    @(posedge clk);
    model_edge(e);
    #1;
  endtask

  task automatic idle();
    idex_memread  = 1'b0;
    idex_rd       = '0;
    ifid_rs1      = '0;
    ifid_rs2      = '0;
    ifid_uses_rs2 = 1'b0;
    branch_taken  = 1'b0;
    mem_busy      = 1'b0;
    clr_cnt       = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m_halted = 0; m_pending = 0; m_busy_run = 0; m_stall = 0; m_flush = 0;
    @(negedge clk);
    check("rst_ctrl", 32'(ctrl_w), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);
    check("rst_flush", 32'(flush_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic set_lu(input logic [RW-1:0] rd);
    idex_memread = 1'b1;
    idex_rd      = rd;
    ifid_rs1     = rd;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #2;
    do_reset();

    // Load-use stall, then rd=0 never stalls
    set_lu(5'd5);
    step();
    check("lu_ctrl", 32'(last_ctrl), 32'h1D);
    idle();
    step();
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    set_lu(5'd0);
    step();
    check("rd0_ctrl", 32'(last_ctrl), 32'h7C);

    // rs2 only counts when the instruction reads it
    idle();
    idex_memread = 1'b1; idex_rd = 5'd7; ifid_rs1 = 5'd3; ifid_rs2 = 5'd7;
    step();
    check("rs2_unused", 32'(last_ctrl), 32'h7C);
    ifid_uses_rs2 = 1'b1;
    step();
    check("rs2_used", 32'(last_ctrl), 32'h1D);

    // Branch beats load-use
    do_reset();
    set_lu(5'd9);
    branch_taken = 1'b1;
    step();
    check("br_vs_lu", 32'(last_ctrl), 32'h7F);
    idle();
    step();
    check("br_vs_lu_flush", 32'(flush_cnt), 32'd1);
    check("br_vs_lu_stall", 32'(stall_cnt), 32'd0);

    // Branch during a 3-cycle freeze is applied once afterwards
    do_reset();
    branch_taken = 1'b1; mem_busy = 1'b1;
    step();
    check("frz0", 32'(last_ctrl), 32'h00);
    branch_taken = 1'b0;
    step();
    step();
    check("frz2", 32'(last_ctrl), 32'h00);
    mem_busy = 1'b0;
    step();
    check("frz_flush", 32'(last_ctrl), 32'h7F);
    step();
    check("frz_after", 32'(last_ctrl), 32'h7C);
    check("frz_stall", 32'(stall_cnt), 32'd3);
    check("frz_flushcnt", 32'(flush_cnt), 32'd1);

    // Watchdog halts on the 4th consecutive busy edge and stays halted
    do_reset();
    mem_busy = 1'b1;
    repeat (TO) step();
    mem_busy = 1'b0;
    step();
    check("wd_halted", 32'(halted), 32'd1);
    check("wd_ctrl", 32'(last_ctrl), 32'h00);
    step();
    do_reset();
    step();
    check("wd_recover", 32'(last_ctrl), 32'h7C);

    // Saturation and clear
    do_reset();
    set_lu(5'd4);
    repeat (20) step();
    check("sat_stall", 32'(stall_cnt), 32'(CMAX));
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    step();
    check("clr_stall", 32'(stall_cnt), 32'd1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      idex_memread  = 1'($urandom_range(0, 1));
      idex_rd       = RW'($urandom_range(0, 3));
      ifid_rs1      = RW'($urandom_range(0, 3));
      ifid_rs2      = RW'($urandom_range(0, 3));
      ifid_uses_rs2 = 1'($urandom_range(0, 1));
      branch_taken  = ($urandom_range(0, 5) == 0);
      mem_busy      = ($urandom_range(0, 3) == 0);
      clr_cnt       = !m_halted && ($urandom_range(0, 40) == 0);
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 300) == 0) begin
        idle();
        do_reset();
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
